// File: rtl/hb3_multi_drive.sv
// NUM_CH-channel PMOD HB3 H-bridge driver: PWM, direction with brake dead-time, SA speed measurement.
// Optional macro HB3_SOFTSTART_EN: duty_eff ramps one LSB per PWM period toward duty.
module hb3_multi_drive #(
    parameter int NUM_CH       = 2,
    parameter int PWM_W        = 8,
    parameter int PRESCALE     = 1,
    parameter int DEADTIME_CYC = 4,
    parameter int SA_WINDOW    = 100000
) (
    input  logic                    sys_clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [NUM_CH*PWM_W-1:0] duty,
    input  logic [NUM_CH-1:0]       dir_req,
    input  logic [NUM_CH-1:0]       sa_in,
    output logic [NUM_CH-1:0]       dir_out,
    output logic [NUM_CH-1:0]       pwm_out,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH*16-1:0]    speed_count,
    output logic                    speed_valid
);

    localparam int PRESC_W = $clog2(PRESCALE + 1);
    localparam int DEAD_W  = $clog2(DEADTIME_CYC + 1);
    localparam int WIN_W   = $clog2(SA_WINDOW + 1);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);
    localparam logic [DEAD_W-1:0]  DEAD_LAST  = DEAD_W'(DEADTIME_CYC - 1);
    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(SA_WINDOW - 1);
    // Counter runs 0..2^PWM_W-2, so a full-scale duty keeps the output permanently high.
    localparam logic [PWM_W-1:0]   CNT_LAST   = {{(PWM_W-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BRAKE  = 2'd1,
        SWITCH = 2'd2
    } ch_state_t;

    logic [PRESC_W-1:0] presc_q;
    logic               tick;

    assign tick = enable && (presc_q == PRESC_LAST);

    always_ff @(posedge sys_clock) begin
        if (!reset || !enable) begin
            presc_q <= '0;
        end else begin
            presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ch_state_t          state_q, state_d;
        logic [PWM_W-1:0]   cnt_q, cnt_d;
        logic [PWM_W-1:0]   duty_eff_q, duty_eff_d;
        logic [PWM_W-1:0]   duty_tgt, next_duty, eff;
        logic [DEAD_W-1:0]  dead_q, dead_d;
        logic               dir_q, dir_d;
        logic               pwm_q, pwm_d;

        assign duty_tgt = duty[i*PWM_W +: PWM_W];

`ifdef HB3_SOFTSTART_EN
        assign next_duty = (duty_tgt > duty_eff_q) ? duty_eff_q + 1'b1 :
                           (duty_tgt < duty_eff_q) ? duty_eff_q - 1'b1 : duty_eff_q;
`else
        assign next_duty = duty_tgt;
`endif

        always_ff @(posedge sys_clock) begin
            if (!reset) begin
                state_q    <= RUN;
                cnt_q      <= '0;
                duty_eff_q <= '0;
                dead_q     <= '0;
                dir_q      <= 1'b0;
                pwm_q      <= 1'b0;
            end else begin
                state_q    <= state_d;
                cnt_q      <= cnt_d;
                duty_eff_q <= duty_eff_d;
                dead_q     <= dead_d;
                dir_q      <= dir_d;
                pwm_q      <= pwm_d;
            end
        end

        // Duty is only adopted when the counter sits at 0, so a period is never cut short.
        always_comb begin
            state_d    = state_q;
            cnt_d      = cnt_q;
            duty_eff_d = duty_eff_q;
            dead_d     = dead_q;
            dir_d      = dir_q;
            pwm_d      = pwm_q;
            eff        = duty_eff_q;
            if (!enable) begin
                state_d = RUN;
                cnt_d   = '0;
                dead_d  = '0;
                pwm_d   = 1'b0;
`ifdef HB3_SOFTSTART_EN
                duty_eff_d = '0;
`endif
            end else begin
                case (state_q)
                    RUN: begin
                        if (dir_req[i] != dir_q) begin
                            state_d = BRAKE;
                            dead_d  = '0;
                            pwm_d   = 1'b0;
                        end else if (tick) begin
                            if (cnt_q == '0) begin
                                eff = next_duty;
                            end
                            duty_eff_d = eff;
                            pwm_d      = (cnt_q < eff);
                            cnt_d      = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
                        end
                    end
                    BRAKE: begin
                        pwm_d = 1'b0;
                        if (dead_q == DEAD_LAST) begin
                            state_d = SWITCH;
                        end else begin
                            dead_d = dead_q + 1'b1;
                        end
                    end
                    SWITCH: begin
                        dir_d   = dir_req[i];
                        cnt_d   = '0;
                        pwm_d   = 1'b0;
                        state_d = RUN;
`ifdef HB3_SOFTSTART_EN
                        duty_eff_d = '0;
`endif
                    end
                    default: begin
                        state_d = RUN;
                    end
                endcase
            end
        end

        assign dir_out[i] = dir_q;
        assign pwm_out[i] = pwm_q;
        assign busy[i]    = (state_q == BRAKE);
    end

    logic [NUM_CH-1:0] sa_s1, sa_s2, sa_d, sa_rise;
    logic [15:0]       edge_cnt [NUM_CH];
    logic [WIN_W-1:0]  win_q;
    logic              win_wrap;

    assign sa_rise  = sa_s2 & ~sa_d;
    assign win_wrap = (win_q == WIN_LAST);

    always_ff @(posedge sys_clock) begin
        if (!reset) begin
            sa_s1 <= '0;
            sa_s2 <= '0;
            sa_d  <= '0;
        end else begin
            sa_s1 <= sa_in;
            sa_s2 <= sa_s1;
            sa_d  <= sa_s2;
        end
    end

    // An edge seen in the wrap cycle seeds the new window instead of the reported one.
    always_ff @(posedge sys_clock) begin
        if (!reset) begin
            win_q       <= '0;
            speed_valid <= 1'b0;
            speed_count <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                edge_cnt[i] <= '0;
            end
        end else begin
            speed_valid <= win_wrap;
            win_q       <= win_wrap ? '0 : win_q + 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (win_wrap) begin
                    speed_count[i*16 +: 16] <= edge_cnt[i];
                    edge_cnt[i]             <= {15'd0, sa_rise[i]};
                end else if (sa_rise[i] && (edge_cnt[i] != 16'hFFFF)) begin
                    edge_cnt[i] <= edge_cnt[i] + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hb3_multi_drive.sv
// Scoreboard bench for hb3_multi_drive: timeline model of PWM/brake/speed, per-cycle monitor.
module tb_hb3_multi_drive;

    localparam int NUM_CH       = 2;
    localparam int PWM_W        = 8;
    localparam int PRESCALE     = 1;
    localparam int DEADTIME_CYC = 4;
    localparam int SA_WINDOW    = 1000;
    localparam int PERIOD       = 255;

    logic        sys_clock = 1'b0;
    logic        reset     = 1'b0;
    logic        enable    = 1'b0;
    logic [15:0] duty      = '0;
    logic [1:0]  dir_req   = '0;
    logic [1:0]  sa_in     = '0;
    logic [1:0]  dir_out, pwm_out, busy;
    logic [31:0] speed_count;
    logic        speed_valid;

    hb3_multi_drive #(
        .NUM_CH(NUM_CH), .PWM_W(PWM_W), .PRESCALE(PRESCALE),
        .DEADTIME_CYC(DEADTIME_CYC), .SA_WINDOW(SA_WINDOW)
    ) dut (
        .sys_clock(sys_clock), .reset(reset), .enable(enable), .duty(duty),
        .dir_req(dir_req), .sa_in(sa_in), .dir_out(dir_out), .pwm_out(pwm_out),
        .busy(busy), .speed_count(speed_count), .speed_valid(speed_valid)
    );

    always #5 sys_clock = ~sys_clock;

    typedef struct packed {
        logic [1:0]  dir;
        logic [1:0]  pwm;
        logic [1:0]  busy;
        logic        valid;
        logic [31:0] speed;
    } exp_t;

    exp_t exp_q[$];
    exp_t pending;
    bit   have_pending = 0;
    int   checks = 0;
    int   errors = 0;

    // Model: each channel is described by its period origin, latched duty and reversal start cycle.
    int   t = 0;
    int   since_rel = 0;
    int   origin[2];
    int   rev_at[2];
    int   lat[2];
    bit   m_dir[2];
    bit   prev_sa[2];
    int   edge_tot[2];
    int   land0[$];
    int   land1[$];
    logic [31:0] m_speed = '0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (time %0t)", name, actual, expected, $time);
        end
    endtask

    task automatic modelStep(input bit rst_n, input bit en, input logic [15:0] dty,
                             input logic [1:0] dreq, input logic [1:0] sa);
        exp_t e;
        int   d, ph, k, land;
        e = '0;
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                m_dir[c] = 0; rev_at[c] = -1; origin[c] = t + 1; lat[c] = 0;
                edge_tot[c] = 0; prev_sa[c] = 0;
            end
            land0.delete();
            land1.delete();
            m_speed   = '0;
            since_rel = 0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                d = int'(dty[c*8 +: 8]);
                if (!en) begin
                    rev_at[c] = -1;
                    origin[c] = t + 1;
`ifdef HB3_SOFTSTART_EN
                    lat[c] = 0;
`endif
                end else if (rev_at[c] < 0) begin
                    if (dreq[c] != m_dir[c]) begin
                        rev_at[c] = t;
                        e.busy[c] = 1'b1;
                    end else begin
                        ph = (t - origin[c]) % PERIOD;
                        if (ph == 0) begin
`ifdef HB3_SOFTSTART_EN
                            if (lat[c] < d) lat[c]++;
                            else if (lat[c] > d) lat[c]--;
`else
                            lat[c] = d;
`endif
                        end
                        e.pwm[c] = (ph < lat[c]);
                    end
                end else begin
                    k = t - rev_at[c];
                    if (k < DEADTIME_CYC) begin
                        e.busy[c] = 1'b1;
                    end else if (k > DEADTIME_CYC) begin
                        m_dir[c]  = dreq[c];
                        origin[c] = t + 1;
                        rev_at[c] = -1;
`ifdef HB3_SOFTSTART_EN
                        lat[c] = 0;
`endif
                    end
                end
                e.dir[c] = m_dir[c];
            end
            // Sensor edges reach the counters two cycles after they appear on the pins.
            if (sa[0] && !prev_sa[0]) land0.push_back(t + 2);
            if (sa[1] && !prev_sa[1]) land1.push_back(t + 2);
            prev_sa[0] = sa[0];
            prev_sa[1] = sa[1];
            for (int c = 0; c < 2; c++) begin
                land = 0;
                if (c == 0 && land0.size() > 0 && land0[0] == t) begin land = 1; void'(land0.pop_front()); end
                if (c == 1 && land1.size() > 0 && land1[0] == t) begin land = 1; void'(land1.pop_front()); end
                if ((since_rel % SA_WINDOW) == SA_WINDOW - 1) begin
                    m_speed[c*16 +: 16] = 16'(edge_tot[c]);
                    edge_tot[c] = land;
                end else begin
                    edge_tot[c] = (edge_tot[c] + land > 65535) ? 65535 : edge_tot[c] + land;
                end
            end
            e.valid = ((since_rel % SA_WINDOW) == SA_WINDOW - 1);
            since_rel++;
        end
        e.speed = m_speed;
        pending = e;
        have_pending = 1;
        t++;
    endtask

    task automatic applyStimulus(input bit rst_n, input bit en, input logic [15:0] dty,
                                 input logic [1:0] dreq, input logic [1:0] sa);
        @(posedge sys_clock);
        #1;
        if (have_pending) exp_q.push_back(pending);
        reset   = rst_n;
        enable  = en;
        duty    = dty;
        dir_req = dreq;
        sa_in   = sa;
        modelStep(rst_n, en, dty, dreq, sa);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge sys_clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("dir_out", 32'(dir_out), 32'(e.dir));
                checkOutput("pwm_out", 32'(pwm_out), 32'(e.pwm));
                checkOutput("busy", 32'(busy), 32'(e.busy));
                checkOutput("speed_valid", 32'(speed_valid), 32'(e.valid));
                if (speed_valid || e.valid) checkOutput("speed_count", speed_count, e.speed);
            end
        end
    end

    initial begin : stimulus
        logic [15:0] d;
        logic [1:0]  dq, sa;
        bit          en, rst;
        int          idx, sel;
        logic [7:0]  v;

        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 16'h0, 2'b00, 2'b00);

        d  = {8'd255, 8'd64};
        dq = 2'b00;
        for (int i = 0; i < 1200; i++) begin
            sa = 2'b00;
            sa[0] = (i < 400) && (((i / 20) % 2) == 1);
            if (i == 355) d[7:0] = 8'd128;
            if (i == 800) dq[0] = 1'b1;
            if (i == 900) dq[1] = 1'b1;
            if (i == 902) dq[1] = 1'b0;
            applyStimulus(1, 1, d, dq, sa);
        end

        dq[0] = 1'b0;
        applyStimulus(1, 1, d, dq, 2'b00);
        applyStimulus(1, 1, d, dq, 2'b00);
        applyStimulus(0, 1, d, dq, 2'b00);
        applyStimulus(0, 1, d, dq, 2'b00);
        $display("[TB] directed section complete, starting random section");

        en  = 1;
        sa  = 2'b00;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                idx = $urandom_range(0, 1);
                sel = $urandom_range(0, 3);
                case (sel)
                    0:       v = 8'd0;
                    1:       v = 8'd255;
                    2:       v = 8'd1;
                    default: v = 8'($urandom_range(2, 254));
                endcase
                d[idx*8 +: 8] = v;
            end
            if ($urandom_range(0, 199) == 0) begin
                idx = $urandom_range(0, 1);
                dq[idx] = ~dq[idx];
            end
            if (en && $urandom_range(0, 399) == 0) en = 0;
            else if (!en && $urandom_range(0, 9) == 0) en = 1;
            if ($urandom_range(0, 7) == 0) begin
                idx = $urandom_range(0, 1);
                sa[idx] = ~sa[idx];
            end
            rst = ($urandom_range(0, 1999) != 0);
            applyStimulus(rst, en, d, dq, sa);
        end

        applyStimulus(1, en, d, dq, sa);
        @(negedge sys_clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
